instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It owns the program counter and fetches instruction bytes from program memory over a req/ready handshake. It presents the latched instruction to the decode logic and issues the one-cycle register-file write strobe. It resolves conditional jumps (opcode 2'b11) using the condition unit's result, and detects halt and fetch-timeout faults.

Parameters:
ADDR_WIDTH, 8, width of program counter and memory address.
FETCH_TIMEOUT, 15, max cycles FETCH may wait for mem_ready before FAULT (1..255).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
run  in  1  level; permits starting/continuing instruction fetch.
mem_req  out  1  program-memory read request.
mem_addr  out  ADDR_WIDTH  read address (equals pc).
mem_ready  in  1  memory data valid; sampled only in FETCH.
mem_rdata  in  8  instruction byte.
instr  out  8  latched instruction (opcode = [7:6], arg0 = [2:0], arg1 = [5:3]).
instr_valid  out  1  instr stable for DECODE/EXECUTE/WRITEBACK.
regs_set  out  1  register-file write strobe, exactly one cycle per non-jump instruction.
cond_result  in  1  condition unit outcome, sampled in EXECUTE for opcode 2'b11.
jump_target  in  ADDR_WIDTH  jump destination, sampled with cond_result.
pc  out  ADDR_WIDTH  program counter.
state  out  3  current FSM state encoding (debug).
halted  out  1  sticky halt flag.
fault  out  1  sticky fetch-timeout flag.

Behaviour:
- All outputs registered. With reset low (async): state=IDLE, pc=0, mem_req=0, instr=8'h00, instr_valid=0, regs_set=0, halted=0, fault=0, wait counter=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, FAULT=6.
- IDLE: all strobes 0. If run=1, go to FETCH next cycle.
- FETCH:
  - mem_req=1 and mem_addr=pc held stable.
  - On an edge with mem_ready=1: latch instr<=mem_rdata, mem_req<=0, clear counter, go to DECODE.
  - Otherwise increment counter. If counter reaches FETCH_TIMEOUT with no ready: mem_req<=0, fault<=1, go to FAULT.
  - mem_ready asserted in the same cycle the request first appears is accepted (zero-wait memory gives a 1-cycle FETCH).
- DECODE (1 cycle):
  - instr_valid=1 from DECODE through end of EXECUTE/WRITEBACK; 0 elsewhere.
  - instr==8'hFF: go to HALT, pc unchanged.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle, datapath settles):
  - Opcode 2'b11: if cond_result=1, pc<=jump_target; else pc<=pc+1. No regs_set. Then go to FETCH if run=1, else IDLE.
  - Opcodes 2'b00/01/10: go to WRITEBACK.
- WRITEBACK (1 cycle): regs_set=1 this cycle only, pc<=pc+1. Then go to FETCH if run=1, else IDLE.
- pc arithmetic is modulo 2^ADDR_WIDTH: 8'hFF+1 -> 8'h00, no flag.
- Latency, zero-wait memory: non-jump instruction 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK); jump 3 cycles.
- run deassert mid-instruction: current instruction completes, including regs_set and pc update; then IDLE. run is ignored outside IDLE and the end-of-instruction decision.
- HALT: halted=1 and held; all strobes 0; only reset exits. FAULT likewise with fault=1.
- Reset asserted mid-operation: mem_req and regs_set drop immediately (async), no partial pc update. On reset release, starts in IDLE.
- mem_ready outside FETCH is ignored; mem_rdata is never latched outside FETCH.

Test Plan:
- Reset then run=1, zero-wait memory with mem[0]=8'h41 (ALU) -> FETCH/DECODE/EXECUTE/WRITEBACK; regs_set high exactly 1 cycle on cycle 4; pc 0->1; instr=8'h41.
- mem_ready delayed 3 cycles -> mem_req and mem_addr held stable 4 cycles; instruction completes normally; no fault.
- mem[5]=8'hC2 with cond_result=1 and jump_target=8'h20 -> pc=8'h20, no regs_set. Repeat with cond_result=0 -> pc=8'h06.
- pc=8'hFF executing 8'h8B (copy) -> regs_set pulse; pc wraps to 8'h00.
- mem_ready held 0 for FETCH_TIMEOUT cycles -> fault=1, state=6, mem_req=0; stays until reset. Separately, instr 8'hFF -> halted=1, pc unchanged.
- run dropped during EXECUTE of 8'h00 -> WRITEBACK still pulses regs_set, then IDLE. Reset pulsed low during FETCH -> mem_req=0 immediately, pc=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : fetch/decode/execute sequencer owning the program counter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int ADDR_WIDTH    = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            instr,
  output logic                  instr_valid,
  output logic                  regs_set,
  input  logic                  cond_result,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [7:0] c_timeout = 8'(FETCH_TIMEOUT);
  localparam logic [7:0] c_halt_op = 8'hFF;

  state_t                r_state,       w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc,          w_pc_nxt;
  logic                  r_mem_req,     w_mem_req_nxt;
  logic [7:0]            r_instr,       w_instr_nxt;
  logic                  r_instr_valid, w_instr_valid_nxt;
  logic                  r_regs_set,    w_regs_set_nxt;
  logic                  r_halted,      w_halted_nxt;
  logic                  r_fault,       w_fault_nxt;
  logic [7:0]            r_wait_cnt,    w_wait_cnt_nxt;
  logic [7:0]            w_wait_inc;
  logic [ADDR_WIDTH-1:0] w_pc_inc;

  assign w_wait_inc = r_wait_cnt + 8'd1;
  assign w_pc_inc   = r_pc + ADDR_WIDTH'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_mem_req     <= 1'b0;
      r_instr       <= 8'h00;
      r_instr_valid <= 1'b0;
      r_regs_set    <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_wait_cnt    <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_regs_set    <= w_regs_set_nxt;
      r_halted      <= w_halted_nxt;
      r_fault       <= w_fault_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

  // Next-state logic also produces the next value of every registered output,
  // so each strobe is high exactly in the state it belongs to.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_mem_req_nxt     = 1'b0;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = 1'b0;
    w_regs_set_nxt    = 1'b0;
    w_halted_nxt      = r_halted;
    w_fault_nxt       = r_fault;
    w_wait_cnt_nxt    = r_wait_cnt;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt    = S_FETCH;
          w_mem_req_nxt  = 1'b1;
          w_wait_cnt_nxt = 8'd0;
        end
      end

      S_FETCH: begin
        if (mem_ready) begin
          w_instr_nxt       = mem_rdata;
          w_instr_valid_nxt = 1'b1;
          w_wait_cnt_nxt    = 8'd0;
          w_state_nxt       = S_DECODE;
        end else if (w_wait_inc >= c_timeout) begin
          w_wait_cnt_nxt = w_wait_inc;
          w_fault_nxt    = 1'b1;
          w_state_nxt    = S_FAULT;
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
          w_mem_req_nxt  = 1'b1;
        end
      end

      S_DECODE: begin
        if (r_instr == c_halt_op) begin
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end else begin
          w_instr_valid_nxt = 1'b1;
          w_state_nxt       = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        if (r_instr[7:6] == 2'b11) begin
          w_pc_nxt = cond_result ? jump_target : w_pc_inc;
          if (run) begin
            w_state_nxt   = S_FETCH;
            w_mem_req_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_instr_valid_nxt = 1'b1;
          w_regs_set_nxt    = 1'b1;
          w_state_nxt       = S_WRITEBACK;
        end
      end

      S_WRITEBACK: begin
        w_pc_nxt = w_pc_inc;
        if (run) begin
          w_state_nxt   = S_FETCH;
          w_mem_req_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_HALT:  w_state_nxt = S_HALT;
      S_FAULT: w_state_nxt = S_FAULT;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign regs_set    = r_regs_set;
  assign pc          = r_pc;
  assign state       = r_state;
  assign halted      = r_halted;
  assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer : random + directed bench against an instruction-level model
// Revision           : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_sequencer;

  localparam int AW  = 8;
  localparam int TMO = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic          run;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [7:0]    mem_rdata;
  logic [7:0]    instr;
  logic          instr_valid;
  logic          regs_set;
  logic          cond_result;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] pc;
  logic [2:0]    state;
  logic          halted;
  logic          fault;

  int         n_checks = 0;
  int         n_errors = 0;
  string      ctx = "init";
  logic [7:0] mem [256];
  int         lat_target = 0;
  int         lat_cnt = 0;
  logic [7:0] mpc;
  logic [7:0] minstr;

  instr_sequencer #(
    .ADDR_WIDTH   (AW),
    .FETCH_TIMEOUT(TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .regs_set   (regs_set),
    .cond_result(cond_result),
    .jump_target(jump_target),
    .pc         (pc),
    .state      (state),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", ctx, tag, got, exp);
    end
  endtask

  // Memory responds after lat_target wait cycles; outside a request the
  // ready/data lines carry noise that the sequencer must ignore.
  task automatic step();
    if (mem_req === 1'b1) begin
      mem_ready = (lat_cnt >= lat_target);
      mem_rdata = mem[mem_addr];
      lat_cnt++;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      lat_cnt   = 0;
    end
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction starting in its first FETCH cycle and checks it
  // against the architectural effect predicted from the instruction byte.
  task automatic exec_one(input int lat, input logic jc, input logic [7:0] jt,
                          input logic run_after);
    int         cycles, rs, iv, req, bad_addr;
    int         e_cycles, e_rs, e_iv, e_req;
    logic [2:0] prev, e_state;
    logic [7:0] opc, ins;

    lat_target  = lat;
    cond_result = jc;
    jump_target = jt;
    run         = run_after;
    opc         = mpc;
    ins         = mem[mpc];
    cycles = 0; rs = 0; iv = 0; req = 1;
    bad_addr = (mem_addr !== opc) ? 1 : 0;
    chk("entry state", state, 3'd1);
    prev = state;
    while (cycles < 64) begin
      step();
      cycles++;
      if (state == 3'd0 || state == 3'd5 || state == 3'd6 || (state == 3'd1 && prev != 3'd1))
        break;
      rs += int'(regs_set);
      iv += int'(instr_valid);
      if (mem_req) begin
        req++;
        if (mem_addr !== opc) bad_addr++;
      end
      prev = state;
    end

    if (lat >= TMO) begin
      e_cycles = TMO; e_rs = 0; e_iv = 0; e_req = TMO; e_state = 3'd6;
    end else begin
      e_req  = lat + 1;
      minstr = ins;
      if (ins == 8'hFF) begin
        e_cycles = lat + 2; e_rs = 0; e_iv = 1; e_state = 3'd5;
      end else if (ins[7:6] == 2'b11) begin
        mpc      = jc ? jt : mpc + 8'd1;
        e_cycles = lat + 3; e_rs = 0; e_iv = 2; e_state = run_after ? 3'd1 : 3'd0;
      end else begin
        mpc      = mpc + 8'd1;
        e_cycles = lat + 4; e_rs = 1; e_iv = 3; e_state = run_after ? 3'd1 : 3'd0;
      end
    end

    chk("cycles",      cycles,   e_cycles);
    chk("regs_set n",  rs,       e_rs);
    chk("instr_valid", iv,       e_iv);
    chk("req cycles",  req,      e_req);
    chk("addr stable", bad_addr, 0);
    chk("pc",          pc,       mpc);
    chk("end state",   state,    e_state);
    chk("instr",       instr,    minstr);
    chk("halted",      halted,   e_state == 3'd5);
    chk("fault",       fault,    e_state == 3'd6);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    mpc    = 8'h00;
    minstr = 8'h00;
  endtask

  task automatic start_fetch();
    run = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
    cond_result = 1'b0; jump_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h41; mem[8'h01] = 8'h12; mem[8'h02] = 8'hC0;
    mem[8'h05] = 8'hC2; mem[8'h20] = 8'hC5; mem[8'h06] = 8'hC7;
    mem[8'hFF] = 8'h8B;

    ctx = "reset";
    step();
    step();
    chk("state", state, 3'd0);    chk("pc", pc, 8'h00);
    chk("mem_req", mem_req, 0);   chk("instr", instr, 8'h00);
    chk("instr_valid", instr_valid, 0); chk("regs_set", regs_set, 0);
    chk("halted", halted, 0);     chk("fault", fault, 0);
    #2 reset = 1'b1;
    mpc = 8'h00; minstr = 8'h00;
    step();
    chk("idle hold", state, 3'd0);

    ctx = "alu 41 zero-wait";
    lat_target = 0;
    run = 1'b1;
    step();
    chk("c1 state", state, 3'd1); chk("c1 req", mem_req, 1); chk("c1 addr", mem_addr, 8'h00);
    run = 1'b0;
    step();
    chk("c2 state", state, 3'd2); chk("c2 instr", instr, 8'h41);
    chk("c2 valid", instr_valid, 1); chk("c2 req", mem_req, 0);
    step();
    chk("c3 state", state, 3'd3); chk("c3 regs_set", regs_set, 0);
    step();
    chk("c4 state", state, 3'd4); chk("c4 regs_set", regs_set, 1); chk("c4 pc", pc, 8'h00);
    step();
    chk("c5 state", state, 3'd0); chk("c5 regs_set", regs_set, 0);
    chk("c5 pc", pc, 8'h01); chk("c5 valid", instr_valid, 0);
    mpc = 8'h01; minstr = 8'h41;

    ctx = "directed sequence";
    start_fetch();
    exec_one(3,  1'b0, 8'h00, 1'b1);  // 12 @01, ready after 3 waits
    exec_one(0,  1'b1, 8'h05, 1'b1);  // C0 @02 -> 05
    exec_one(0,  1'b1, 8'h20, 1'b1);  // C2 @05 taken -> 20
    exec_one(1,  1'b1, 8'h05, 1'b1);  // C5 @20 -> 05
    exec_one(0,  1'b0, 8'h20, 1'b1);  // C2 @05 not taken -> 06
    exec_one(TMO - 1, 1'b1, 8'hFF, 1'b1);  // ready on last allowed cycle
    exec_one(1,  1'b0, 8'h00, 1'b1);  // 8B @FF, pc wraps to 00
    mem[8'h00] = 8'h00;
    exec_one(0,  1'b0, 8'h00, 1'b0);  // run low throughout: completes, then IDLE

    ctx = "reset in fetch";
    lat_target = 10;
    start_fetch();
    step();
    step();
    chk("in fetch", state, 3'd1);
    reset = 1'b0;
    #1;
    chk("req async", mem_req, 0); chk("pc async", pc, 8'h00);
    chk("state async", state, 3'd0); chk("instr async", instr, 8'h00);
    run = 1'b0;
    step();
    #2 reset = 1'b1;
    mpc = 8'h00; minstr = 8'h00;
    step();
    chk("post reset", state, 3'd0);

    ctx = "halt";
    mem[8'h00] = 8'hFF;
    start_fetch();
    exec_one(2, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("hold state", state, 3'd5); chk("hold halted", halted, 1);
    chk("hold req", mem_req, 0);    chk("hold pc", pc, 8'h00);
    chk("hold regs_set", regs_set, 0);
    do_reset();
    chk("halt cleared", halted, 0);

    ctx = "fault";
    start_fetch();
    exec_one(1000, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("hold state", state, 3'd6); chk("hold fault", fault, 1);
    chk("hold req", mem_req, 0);
    do_reset();
    chk("fault cleared", fault, 0);

    ctx = "random";
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hFF) mem[i] = 8'h00;
    end
    start_fetch();
    for (int n = 0; n < 150; n++) begin
      exec_one($urandom_range(0, 5), 1'($urandom_range(0, 1)), 8'($urandom),
               $urandom_range(0, 7) != 0);
      if (state == 3'd0) begin
        run = 1'b0;
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
        chk("idle wait", state, 3'd0);
        start_fetch();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
